sha3_1600to64: RTL and testbench

Squeeze-side serializer for the SHA3/SHAKE core. It takes the 1600-bit Keccak state after a permutation and emits the rate or digest portion as 64-bit words over a valid/ready handshake. For SHAKE modes with outputs longer than one rate block, it requests further permutations. It is the output counterpart of the 64-bit absorb packer and sits between the Keccak round engine and the downstream consumer (for example, the Frodo matrix sampler).

---
 rtl/sha3_pkg.sv | 47 ++++
 rtl/sha3_1600to64.sv | 115 +++++++++++
 tb/tb_sha3_1600to64.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3/SHAKE definitions: mode encoding, state width and the per-mode
// word-count table used by both the absorb packer and the squeeze serializer.
package sha3_pkg;

  localparam logic [2:0] SHAKE128 = 3'd0;
  localparam logic [2:0] SHAKE256 = 3'd1;
  localparam logic [2:0] SHA3_512 = 3'd2;
  localparam logic [2:0] SHA3_384 = 3'd3;
  localparam logic [2:0] SHA3_256 = 3'd4;
  localparam logic [2:0] SHA3_224 = 3'd5;

  localparam int SHA3_B   = 1600;
  // Widest rate (SHAKE128, 21 words); every other mode's output fits inside it.
  localparam int SQZ_BITS = 1344;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OUT,
    ST_WAIT
  } sqz_state_e;

  function automatic logic is_shake(input logic [2:0] mode);
    return (mode == SHAKE128) || (mode == SHAKE256);
  endfunction

  function automatic logic [4:0] rate_words(input logic [2:0] mode);
    case (mode)
      SHAKE128: return 5'd21;
      SHAKE256: return 5'd17;
      SHA3_512: return 5'd9;
      SHA3_384: return 5'd13;
      SHA3_224: return 5'd18;
      default:  return 5'd17;
    endcase
  endfunction

  function automatic logic [4:0] digest_words(input logic [2:0] mode);
    case (mode)
      SHAKE128: return 5'd0;
      SHAKE256: return 5'd0;
      SHA3_512: return 5'd8;
      SHA3_384: return 5'd6;
      default:  return 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/sha3_1600to64.sv
// Squeeze-side serializer: emits the rate/digest part of a permuted Keccak
// state as 64-bit words and asks for further permutations on long SHAKE output.
module sha3_1600to64
  import sha3_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    mode_sel_i,
  input  logic [15:0]   out_words_i,
  input  logic [0:1599] state_i,
  input  logic          state_valid_i,
  output logic [0:63]   dout64,
  output logic          dout_valid_o,
  input  logic          dout_ready_i,
  output logic          squeeze_req_o,
  output logic          done_o,
  output logic          busy_o
);

  sqz_state_e            state_q, state_d;
  logic [2:0]            mode_q;
  logic [15:0]           remaining_q;
  logic [4:0]            blk_cnt_q;
  logic [0:SQZ_BITS-1]   sreg_q;

  logic                  start, reload, handshake, done_d, sqz_d;
  logic [15:0]           init_rem;
  logic                  state_unused;

  // The capacity part of the state never leaves the core.
  assign state_unused = ^state_i[SQZ_BITS:SHA3_B-1];

  assign init_rem  = is_shake(mode_sel_i) ? out_words_i : {11'd0, digest_words(mode_sel_i)};
  assign handshake = dout_valid_o & dout_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    reload  = 1'b0;
    done_d  = 1'b0;
    sqz_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (state_valid_i) begin
          start = 1'b1;
          if (init_rem == 16'd0) done_d = 1'b1;
          else                   state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (handshake) begin
          if (remaining_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (blk_cnt_q + 5'd1 == rate_words(mode_q)) begin
            sqz_d   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (state_valid_i) begin
          reload  = 1'b1;
          state_d = ST_OUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= SHAKE128;
      remaining_q   <= '0;
      blk_cnt_q     <= '0;
      sreg_q        <= '0;
      done_o        <= 1'b0;
      squeeze_req_o <= 1'b0;
    end else begin
      done_o        <= done_d;
      squeeze_req_o <= sqz_d;
      if (start) begin
        mode_q      <= mode_sel_i;
        remaining_q <= init_rem;
        blk_cnt_q   <= '0;
        sreg_q      <= state_i[0:SQZ_BITS-1];
      end else if (reload) begin
        blk_cnt_q   <= '0;
        sreg_q      <= state_i[0:SQZ_BITS-1];
      end else if (handshake) begin
        remaining_q <= remaining_q - 16'd1;
        blk_cnt_q   <= blk_cnt_q + 5'd1;
        sreg_q      <= {sreg_q[64:SQZ_BITS-1], 64'd0};
      end
    end
  end

  // Outputs decode straight from registers so a reset drops them at once.
  always_comb begin
    dout64 = '0;
    if (state_q == ST_OUT) begin
      dout64 = sreg_q[0:63];
      if (mode_q == SHA3_224 && remaining_q == 16'd1) dout64[32:63] = '0;
    end
  end

  assign dout_valid_o = (state_q == ST_OUT);
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha3_1600to64.sv
// Directed self-checking bench for the squeeze serializer.
module tb_sha3_1600to64;
  import sha3_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode_sel_i;
  logic [15:0]   out_words_i;
  logic [0:1599] state_i;
  logic          state_valid_i;
  logic [0:63]   dout64;
  logic          dout_valid_o;
  logic          dout_ready_i;
  logic          squeeze_req_o;
  logic          done_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  sha3_1600to64 dut (
    .clk           (clk),
    .reset         (reset),
    .mode_sel_i    (mode_sel_i),
    .out_words_i   (out_words_i),
    .state_i       (state_i),
    .state_valid_i (state_valid_i),
    .dout64        (dout64),
    .dout_valid_o  (dout_valid_o),
    .dout_ready_i  (dout_ready_i),
    .squeeze_req_o (squeeze_req_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  // Word k of the state holds base + k.
  function automatic logic [0:1599] make_state(input logic [63:0] base);
    logic [0:1599] s;
    for (int k = 0; k < 25; k++) s[64*k +: 64] = base + 64'(k);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are scrambled after the load so a missing latch shows up.
  task automatic load(input logic [2:0] m, input logic [15:0] n, input logic [0:1599] st);
    mode_sel_i    = m;
    out_words_i   = n;
    state_i       = st;
    state_valid_i = 1'b1;
    step();
    state_valid_i = 1'b0;
    mode_sel_i    = ~m;
    out_words_i   = 16'hFFFF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (dout_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", dout_valid_o); end
    checks++; if (dout64 !== 64'd0) begin errors++; $display("[TB] FAIL reset_dout got %h want 0", dout64); end
    checks++; if ({done_o, squeeze_req_o, busy_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {done_o, squeeze_req_o, busy_o}); end
    reset = 1'b0;
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy_o); end
  endtask

  task automatic test_sha3_256();
    dout_ready_i = 1'b1;
    load(SHA3_256, 16'd0, make_state(64'd0));
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL s256_valid%0d got %b want 1", k, dout_valid_o); end
      checks++; if (dout64 !== 64'(k)) begin errors++; $display("[TB] FAIL s256_word%0d got %h want %h", k, dout64, 64'(k)); end
      checks++; if ({done_o, squeeze_req_o} !== 2'b00) begin errors++; $display("[TB] FAIL s256_pulse%0d got %b want 00", k, {done_o, squeeze_req_o}); end
      step();
    end
    checks++; if ({done_o, dout_valid_o, squeeze_req_o} !== 3'b100) begin errors++; $display("[TB] FAIL s256_done got %b want 100", {done_o, dout_valid_o, squeeze_req_o}); end
    step();
    checks++; if ({done_o, busy_o} !== 2'b00) begin errors++; $display("[TB] FAIL s256_after got %b want 00", {done_o, busy_o}); end
  endtask

  task automatic test_sha3_224();
    logic [0:1599] st;
    logic [63:0]   exp;
    st = make_state(64'd0);
    st[192 +: 64] = 64'hAABBCCDD_11223344;
    dout_ready_i = 1'b1;
    load(SHA3_224, 16'd0, st);
    for (int k = 0; k < 4; k++) begin
      exp = (k == 3) ? 64'hAABBCCDD_00000000 : 64'(k);
      checks++; if (dout64 !== exp) begin errors++; $display("[TB] FAIL s224_word%0d got %h want %h", k, dout64, exp); end
      step();
    end
    checks++; if ({done_o, dout_valid_o} !== 2'b10) begin errors++; $display("[TB] FAIL s224_done got %b want 10", {done_o, dout_valid_o}); end
    step();
  endtask

  task automatic test_shake128();
    dout_ready_i = 1'b1;
    load(SHAKE128, 16'd25, make_state(64'h1000));
    for (int k = 0; k < 21; k++) begin
      checks++; if (dout64 !== 64'h1000 + 64'(k)) begin errors++; $display("[TB] FAIL s128_a%0d got %h want %h", k, dout64, 64'h1000 + 64'(k)); end
      step();
    end
    checks++; if ({squeeze_req_o, dout_valid_o, busy_o, done_o} !== 4'b1010) begin errors++; $display("[TB] FAIL s128_sqz got %b want 1010", {squeeze_req_o, dout_valid_o, busy_o, done_o}); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({squeeze_req_o, dout_valid_o} !== 2'b00) begin errors++; $display("[TB] FAIL s128_wait%0d got %b want 00", k, {squeeze_req_o, dout_valid_o}); end
    end
    state_i       = make_state(64'h2000);
    state_valid_i = 1'b1;
    step();
    state_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (dout64 !== 64'h2000 + 64'(k)) begin errors++; $display("[TB] FAIL s128_b%0d got %h want %h", k, dout64, 64'h2000 + 64'(k)); end
      step();
    end
    checks++; if ({done_o, dout_valid_o, squeeze_req_o} !== 3'b100) begin errors++; $display("[TB] FAIL s128_done got %b want 100", {done_o, dout_valid_o, squeeze_req_o}); end
    step();
  endtask

  task automatic test_shake256_stall();
    int          idx = 0;
    int          sqz_cnt = 0;
    logic        finished = 1'b0;
    logic        prev_stall = 1'b0;
    logic [0:63] prev_word = '0;
    logic [63:0] exp;
    dout_ready_i = 1'b0;
    load(SHAKE256, 16'd40, make_state(64'h3000));
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      state_valid_i = 1'b0;
      dout_ready_i  = ((cyc % 2) == 1);
      if (dout_valid_o) begin
        exp = 64'h3000 + 64'(idx / 17) * 64'h100 + 64'(idx % 17);
        checks++; if (dout64 !== exp) begin errors++; $display("[TB] FAIL s256x_word%0d got %h want %h", idx, dout64, exp); end
        if (prev_stall) begin
          checks++; if (dout64 !== prev_word) begin errors++; $display("[TB] FAIL s256x_hold%0d got %h want %h", idx, dout64, prev_word); end
        end
        prev_stall = !dout_ready_i;
        prev_word  = dout64;
        if (dout_ready_i) idx++;
      end else begin
        prev_stall = 1'b0;
      end
      if (squeeze_req_o) begin
        sqz_cnt++;
        state_i       = make_state(64'h3000 + 64'(sqz_cnt) * 64'h100);
        state_valid_i = 1'b1;
      end
      if (done_o) finished = 1'b1;
      else        step();
    end
    state_valid_i = 1'b0;
    checks++; if (finished !== 1'b1) begin errors++; $display("[TB] FAIL s256x_timeout got %b want 1", finished); end
    checks++; if (idx != 40) begin errors++; $display("[TB] FAIL s256x_count got %0d want 40", idx); end
    checks++; if (sqz_cnt != 2) begin errors++; $display("[TB] FAIL s256x_sqz got %0d want 2", sqz_cnt); end
    step();
  endtask

  task automatic test_ignore_and_reset();
    dout_ready_i = 1'b1;
    load(SHA3_512, 16'd0, make_state(64'h5000));
    for (int k = 0; k < 3; k++) begin
      checks++; if (dout64 !== 64'h5000 + 64'(k)) begin errors++; $display("[TB] FAIL ign_word%0d got %h want %h", k, dout64, 64'h5000 + 64'(k)); end
      if (k == 1) begin
        state_i       = make_state(64'h6000);
        state_valid_i = 1'b1;
      end
      step();
      state_valid_i = 1'b0;
    end
    checks++; if (dout64 !== 64'h5003) begin errors++; $display("[TB] FAIL ign_word3 got %h want 5003", dout64); end
    reset = 1'b1;
    #1;
    checks++; if ({dout_valid_o, busy_o, done_o, squeeze_req_o} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_flags got %b want 0000", {dout_valid_o, busy_o, done_o, squeeze_req_o}); end
    checks++; if (dout64 !== 64'd0) begin errors++; $display("[TB] FAIL rst_dout got %h want 0", dout64); end
    reset = 1'b0;
    step();
    load(SHA3_384, 16'd0, make_state(64'h7000));
    for (int k = 0; k < 6; k++) begin
      checks++; if (dout64 !== 64'h7000 + 64'(k)) begin errors++; $display("[TB] FAIL s384_word%0d got %h want %h", k, dout64, 64'h7000 + 64'(k)); end
      step();
    end
    checks++; if ({done_o, dout_valid_o} !== 2'b10) begin errors++; $display("[TB] FAIL s384_done got %b want 10", {done_o, dout_valid_o}); end
    step();
  endtask

  task automatic test_zero_len();
    dout_ready_i = 1'b1;
    load(SHAKE128, 16'd0, make_state(64'h9000));
    checks++; if ({done_o, dout_valid_o, busy_o} !== 3'b100) begin errors++; $display("[TB] FAIL zero_done got %b want 100", {done_o, dout_valid_o, busy_o}); end
    step();
    checks++; if ({done_o, dout_valid_o} !== 2'b00) begin errors++; $display("[TB] FAIL zero_after got %b want 00", {done_o, dout_valid_o}); end
  endtask

  initial begin
    reset         = 1'b1;
    mode_sel_i    = '0;
    out_words_i   = '0;
    state_i       = '0;
    state_valid_i = 1'b0;
    dout_ready_i  = 1'b0;
    test_reset();
    test_sha3_256();
    test_sha3_224();
    test_shake128();
    test_shake256_stall();
    test_ignore_and_reset();
    test_zero_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
